// File: rtl/divu_unit.sv
// divu_unit: iterative unsigned restoring divider, one quotient bit per cycle.
// Produces {remainder, quotient} plus a one-cycle done strobe for the HiLo
// register write path.
//
// Handshake: start is sampled only in IDLE or DONE, and the operands are
// captured on that same edge. While busy is high, start is ignored and no
// request is queued. After the last iteration, done pulses high for exactly
// one cycle with div_ans final. div_ans holds its value until the next done or
// a reset. busy and done are never high together.
module divu_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   div_ans,
   output logic [1:0]           dbg_state_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     d_q;       // latched divisor
   logic [WIDTH-1:0]     q_q;       // dividend shifting out, quotient shifting in
   // The partial remainder is always strictly less than the divisor between
   // iterations, so WIDTH bits hold it. Only the shifted trial value needs
   // the extra bit.
   logic [WIDTH-1:0]     r_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   ans_q;

   logic [WIDTH:0]       r_sh;      // R' = {R, Q} << 1, upper part
   logic [WIDTH:0]       trial;     // R' - {0, D}
   logic [WIDTH-1:0]     r_nxt;
   logic [WIDTH-1:0]     q_nxt;
   logic                 accept;

   // One restoring step: shift, trial-subtract, keep the difference if it is non-negative.
   always_comb begin
      r_sh   = {r_q, q_q[WIDTH-1]};
      trial  = r_sh - {1'b0, d_q};
      r_nxt  = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      q_nxt  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
      accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   // Control FSM and datapath registers; all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ans_q   <= '0;
      end else if (accept) begin
         state_q <= S_RUN;
         d_q     <= divisor;
         q_q     <= dividend;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               r_q   <= r_nxt;
               q_q   <= q_nxt;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST_ITER) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ans_q   <= {r_nxt, q_nxt};
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_ans     = ans_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divu_unit.sv
// tb_divu_unit: directed vectors for divu_unit with hand-computed results.
module tb_divu_unit;

   localparam int W = 32;

   logic           clk;
   logic           reset;
   logic           start;
   logic [W-1:0]   dividend;
   logic [W-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [2*W-1:0] div_ans;
   logic [1:0]     dbg_state;

   int err_cnt = 0;
   int chk_cnt = 0;

   divu_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_ans     (div_ans),
      .dbg_state_o (dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // advance one edge and sample 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a request on the next edge. On return, time is just after the accept edge.
   task automatic accept_req(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Wait for done, counting edges after the accept edge. Returns -1 on timeout.
   // Also counts busy cycles and flags any overlap of busy and done.
   task automatic wait_done(input string tag, output int edges, output int busy_cycles,
                            input int inject_run_cycle);
      int overlap = 0;
      edges       = -1;
      busy_cycles = 0;
      for (int n = 0; n < 40; n++) begin
         if (busy && done) overlap++;
         if (busy) busy_cycles++;
         if (done) begin
            edges = n;
            break;
         end
         // drive a start during RUN cycle n+1 if requested
         if (inject_run_cycle == n + 1) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd3;
         end
         tick();
         start = 1'b0;
      end
      check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
   endtask

   // Count done pulses over n cycles.
   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (done) pulses++;
      end
   endtask

   // Full division: accept, check latency, result, and one-cycle done with held result.
   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp, input int inject_run_cycle);
      int edges, bcyc, pulses;
      accept_req(a, b);
      wait_done(tag, edges, bcyc, inject_run_cycle);
      // done follows the edge WIDTH edges after the accept edge
      // (33 cycles counting the accept cycle)
      check({tag, " latency"}, 64'(edges), 64'(W));
      check({tag, " busy_cycles"}, 64'(bcyc), 64'(W));
      check({tag, " div_ans"}, div_ans, exp);
      tick();
      check({tag, " done_drops"}, 64'(done), 64'd0);
      check({tag, " held"}, div_ans, exp);
      count_done(36, pulses);
      check({tag, " extra_done"}, 64'(pulses), 64'd0);
      check({tag, " idle_after"}, 64'(dbg_state), 64'd0);
   endtask

   // scoreboard-free directed sequence
   initial begin
      int edges, bcyc, pulses;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset div_ans", div_ans, 64'd0);
      check("reset state", 64'(dbg_state), 64'd0);

      // reset wins over a simultaneous start
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      tick();
      start = 1'b0;
      reset = 1'b0;
      check("reset_start busy", 64'(busy), 64'd0);
      tick();
      check("reset_start state", 64'(dbg_state), 64'd0);

      run_div("basic", 32'd100, 32'd7, 64'h00000002_0000000E, -1);
      run_div("max_div1", 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, -1);
      run_div("small_by_max", 32'd5, 32'hFFFFFFFF, 64'h00000005_00000000, -1);
      run_div("zero_div", 32'd0, 32'd3, 64'h0, -1);
      run_div("div_by_zero", 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, -1);
      run_div("start_busy", 32'd100, 32'd7, 64'h00000002_0000000E, 10);

      // back-to-back: start held through the DONE cycle
      accept_req(32'd100, 32'd7);
      wait_done("b2b first", edges, bcyc, -1);
      check("b2b first latency", 64'(edges), 64'(W));
      check("b2b first div_ans", div_ans, 64'h00000002_0000000E);
      accept_req(32'd1000, 32'd10);
      check("b2b busy_rises", 64'(busy), 64'd1);
      check("b2b held_during_run", div_ans, 64'h00000002_0000000E);
      wait_done("b2b second", edges, bcyc, -1);
      // second done is edges+1 edges after the first done
      check("b2b spacing", 64'(edges + 1), 64'(W + 1));
      check("b2b second div_ans", div_ans, 64'h00000000_00000064);
      count_done(36, pulses);
      check("b2b extra_done", 64'(pulses), 64'd0);

      // reset asserted during RUN cycle 20
      accept_req(32'd100, 32'd7);
      for (int n = 1; n < 20; n++) tick();
      check("abort in_run", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort div_ans", div_ans, 64'd0);
      check("abort state", 64'(dbg_state), 64'd0);
      count_done(40, pulses);
      check("abort no_done", 64'(pulses), 64'd0);
      run_div("after_abort", 32'd100, 32'd7, 64'h00000002_0000000E, -1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
